// File: rtl/sprite_lut_loader.sv
// Sprite LUT loader: assembles pixels from a byte stream (hi byte, then lo byte)
// and writes them sequentially into a 2**ADDR_WIDTH-entry colour LUT.
module sprite_lut_loader #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr_w,
  output logic [DATA_WIDTH-1:0] din,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {StIdle, StHi, StLo, StWr, StFin} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  // Only the bits of the hi byte that reach the pixel are kept; the lo byte
  // lives directly in din[7:0] once accepted.
  logic [DATA_WIDTH-9:0] hi_q;
  logic                  we_q;

  // Abort in the write cycle must cancel the write that the registered strobe
  // would otherwise present, so abort gates the strobe on its way out.
  assign we = we_q & ~abort;

  // Single-process FSM; every output is set for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      hi_q       <= '0;
      we_q       <= 1'b0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      addr_w     <= '0;
      din        <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          // Abort beats a simultaneous start.
          if (start && !abort) begin
            state_q    <= StHi;
            cnt_q      <= '0;
            busy       <= 1'b1;
            byte_ready <= 1'b1;
          end
        end
        StHi: begin
          if (abort) begin
            state_q    <= StIdle;
            busy       <= 1'b0;
            byte_ready <= 1'b0;
          end else if (byte_valid) begin
            hi_q    <= byte_in[DATA_WIDTH-9:0];
            state_q <= StLo;
          end
        end
        StLo: begin
          if (abort) begin
            state_q    <= StIdle;
            busy       <= 1'b0;
            byte_ready <= 1'b0;
          end else if (byte_valid) begin
            din        <= {hi_q, byte_in};
            addr_w     <= cnt_q;
            we_q       <= 1'b1;
            byte_ready <= 1'b0;
            state_q    <= StWr;
          end
        end
        StWr: begin
          we_q <= 1'b0;
          if (abort) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else if (cnt_q == LastAddr) begin
            state_q <= StFin;
            done    <= 1'b1;
          end else begin
            cnt_q      <= cnt_q + 1'b1;
            state_q    <= StHi;
            byte_ready <= 1'b1;
          end
        end
        StFin: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q    <= StIdle;
          we_q       <= 1'b0;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_lut_loader.sv
// Bench for sprite_lut_loader: directed stimulus pushes expected LUT writes and
// done pulses into a queue; a negedge monitor pops and compares them.
module tb_sprite_lut_loader;

  logic        clk = 1'b0;
  logic        reset, start, abort, byte_valid;
  logic [7:0]  byte_in;
  logic        byte_ready, we, busy, done;
  logic [9:0]  addr_w;
  logic [11:0] din;

  sprite_lut_loader #(.DATA_WIDTH(12), .ADDR_WIDTH(10)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .we(we), .addr_w(addr_w), .din(din), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_done;
    logic [9:0]  addr;
    logic [11:0] data;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad   = 0;
  logic prev_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    total++;
    bad++;
    $display("FAIL %s: got an output event expected none (addr=0x%0h din=0x%0h)",
             name, addr_w, din);
  endtask

  // Monitor: compare every write and done pulse against the scoreboard.
  always @(negedge clk) begin
    ev_t e;
    if (we) begin
      check("we_one_cycle", {31'b0, prev_we}, 32'd0);
      if (q.size() == 0) fail_event("unexpected_write");
      else begin
        e = q.pop_front();
        check("ev_kind_write", {31'b0, e.is_done}, 32'd0);
        check("addr_w", {22'b0, addr_w}, {22'b0, e.addr});
        check("din", {20'b0, din}, {20'b0, e.data});
      end
    end
    if (done) begin
      if (q.size() == 0) fail_event("unexpected_done");
      else begin
        e = q.pop_front();
        check("ev_kind_done", {31'b0, e.is_done}, 32'd1);
      end
    end
    prev_we = we;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_write(input logic [9:0] a, input logic [11:0] d);
    ev_t e;
    e.is_done = 1'b0;
    e.addr    = a;
    e.data    = d;
    q.push_back(e);
  endtask

  task automatic push_done();
    ev_t e;
    e.is_done = 1'b1;
    e.addr    = '0;
    e.data    = '0;
    q.push_back(e);
  endtask

  // Present one byte after 'gap' idle cycles and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) tick();
    end
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (!byte_ready) begin
      check("byte_accept_timeout", 32'd0, 32'd1);
      return;
    end
    tick();
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check("queue_drained", q.size(), 32'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Full 1024-pixel load; pixel n = n (n < 4096), optional start pulse mid-load.
  task automatic load_image(input int maxgap, input int pulse_at);
    logic [11:0] px;
    do_start();
    for (int n = 0; n < 1024; n++) begin
      if (n == pulse_at) begin
        byte_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      px = n[11:0];
      push_write(n[9:0], px);
      if (n == 1023) push_done();
      send_byte({4'h0, px[11:8]}, (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
      send_byte(px[7:0], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
    end
    byte_valid = 1'b0;
    wait_drain();
    tick();
    check("busy_after_load", {31'b0, busy}, 32'd0);
    check("done_after_load", {31'b0, done}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (3) tick();
    check("rst_we", {31'b0, we}, 32'd0);
    check("rst_ready", {31'b0, byte_ready}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_addr", {22'b0, addr_w}, 32'd0);
    check("rst_din", {20'b0, din}, 32'd0);
    reset = 1'b0;
    tick();

    // Start and abort together in idle: abort wins.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", {31'b0, busy}, 32'd0);
    check("start_abort_ready", {31'b0, byte_ready}, 32'd0);

    // 0xF3, 0xA5 -> 0x3A5 at address 0.
    do_start();
    check("start_busy", {31'b0, busy}, 32'd1);
    check("start_ready", {31'b0, byte_ready}, 32'd1);
    push_write(10'd0, 12'h3A5);
    send_byte(8'hF3, 0);
    send_byte(8'hA5, 0);
    byte_valid = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_hi_busy", {31'b0, busy}, 32'd0);
    wait_drain();

    // Reset while in LO: no partial write, outputs back to reset values.
    do_start();
    send_byte(8'h12, 0);
    byte_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("lo_rst_we", {31'b0, we}, 32'd0);
    check("lo_rst_busy", {31'b0, busy}, 32'd0);
    check("lo_rst_ready", {31'b0, byte_ready}, 32'd0);
    check("lo_rst_done", {31'b0, done}, 32'd0);
    check("lo_rst_addr", {22'b0, addr_w}, 32'd0);
    check("lo_rst_din", {20'b0, din}, 32'd0);
    repeat (3) tick();

    // Five pixels, abort in HI, restart at 0, then abort during a write cycle.
    do_start();
    for (int n = 0; n < 5; n++) begin
      push_write(n[9:0], 12'h150 + n[11:0]);
      send_byte(8'h01, 0);
      send_byte(8'h50 + n[7:0], 0);
    end
    byte_valid = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort5_busy", {31'b0, busy}, 32'd0);
    wait_drain();
    do_start();
    push_write(10'd0, 12'h2C7);
    send_byte(8'h02, 0);
    send_byte(8'hC7, 0);
    send_byte(8'h07, 0);
    send_byte(8'h77, 0);
    byte_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_wr_busy", {31'b0, busy}, 32'd0);
    check("abort_wr_we", {31'b0, we}, 32'd0);
    repeat (3) tick();
    wait_drain();

    // Full load, valid held high, start pulsed at pixel 100 (ignored).
    load_image(0, 100);

    // Full load with random gaps up to 10 cycles.
    load_image(10, -1);

    repeat (3) tick();
    check("final_queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_lut_loader.md
SPRITE_LUT_LOADER -- requirements
Module: sprite_lut_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 12: pixel colour width; legal range 9..16.
REQ-002 Parameter ADDR_WIDTH, default 10: LUT address width; depth = 2**ADDR_WIDTH.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a full-image load at address 0.
REQ-006 abort  input  1  terminates a load in progress; no further writes.
REQ-007 byte_in  input  8  incoming pixel byte stream (e.g. from UART receiver).
REQ-008 byte_valid  input  1  byte_in holds a valid byte.
REQ-009 byte_ready  output  1  loader accepts byte_in this cycle.
REQ-010 we  output  1  LUT write enable, one cycle per pixel.
REQ-011 addr_w  output  ADDR_WIDTH  LUT write address.
REQ-012 din  output  DATA_WIDTH  LUT write data.
REQ-013 busy  output  1  high from load start until return to IDLE.
REQ-014 done  output  1  one-cycle pulse after the final pixel write.

Function
REQ-015 FSM states SHALL be IDLE, HI, LO, WR, FIN; all outputs registered.
REQ-016 Byte handshake: a byte is accepted on a cycle with byte_valid=1 and byte_ready=1; byte_ready SHALL be 1 only in HI and LO.
REQ-017 IDLE: start=1 -> HI next cycle, addr counter cleared to 0, busy=1 from that cycle.
REQ-018 HI: accepted byte stored as hi; -> LO. No byte -> stay HI (no timeout).
REQ-019 LO: accepted byte stored as lo; -> WR.
REQ-020 Pixel SHALL be {hi[DATA_WIDTH-9:0], lo}; unused upper bits of hi ignored.
REQ-021 WR: we=1, addr_w=counter, din=pixel for exactly one cycle (first WR cycle is the cycle after the LO byte is accepted).
REQ-022 WR with counter = 2**ADDR_WIDTH-1 -> FIN; otherwise counter increments by 1 and -> HI.
REQ-023 FIN: done=1 for one cycle, busy=0 after it; -> IDLE. Counter SHALL NOT wrap past last address.
REQ-024 Throughput: one pixel per 3 cycles minimum with byte_valid held high.
REQ-025 start while busy SHALL be ignored (no restart, no counter change).
REQ-026 abort=1 in HI, LO or WR SHALL return to IDLE next cycle, busy=0, done=0; abort in WR SHALL suppress that cycle's we (abort wins over write).
REQ-027 start and abort both high in IDLE: abort wins, stay IDLE.
REQ-028 we SHALL be 0 in every state except WR; addr_w/din hold last values when we=0.
REQ-029 Bytes presented while byte_ready=0 SHALL NOT be consumed.

Reset
REQ-030 reset=1 SHALL, on the next rising edge, force IDLE, counter=0, we=0, byte_ready=0, busy=0, done=0, addr_w=0, din=0, hi=lo=0.
REQ-031 reset mid-load SHALL abandon the load with no further write; reset dominates start and abort.
REQ-032 reset during WR cycle: that we pulse has already occurred; no subsequent write.

Verification
REQ-033 Reset, start, stream 2048 bytes (pixel n = n mod 4096 as hi/lo) with byte_valid=1 -> 1024 writes, addr_w 0..1023 in order, din matches, done pulses once after addr 1023, busy low after.
REQ-034 Bytes 0xF3,0xA5 at address 0 -> din=0x3A5 (upper nibble dropped), we high exactly one cycle.
REQ-035 byte_valid toggled randomly with gaps up to 10 cycles -> identical write sequence to REQ-033, no byte lost or duplicated.
REQ-036 abort after 5 pixels, then start -> writes restart at addr 0, no done from aborted load, no we in abort cycle.
REQ-037 start pulsed at pixel 100 of a load -> ignored; addresses continue 101, 102, ...
REQ-038 reset asserted in LO state -> next cycle all outputs at reset values, no write of partial pixel.
